// File: rtl/l2sw_pkg.sv
// ============================================================================
// l2sw_pkg : shared L2 switch types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package l2sw_pkg;

    localparam int L2SW_MTU     = 1500;
    localparam int L2SW_N_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, search starts at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    always_comb begin
        winner  = '0;
        idx     = '0;
        any     = |req;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = IW'((int'(ptr) + i) % N);
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                winner[w_cand] = 1'b1;
                idx            = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ingress_fifo_arbiter.sv
// ============================================================================
// ingress_fifo_arbiter : frame-atomic round-robin owner of the header/payload
// FIFO pair. Optional grant watchdog: ARB_WATCHDOG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module ingress_fifo_arbiter
    import l2sw_pkg::*;
#(
    parameter int N_PORTS     = L2SW_N_PORTS,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req,
    input  logic [N_PORTS-1:0]         eof,
    input  logic                       H_fifo_afull,
    input  logic                       P_fifo_afull,
    output logic [N_PORTS-1:0]         grant,
    output logic [$clog2(N_PORTS)-1:0] grant_id,
    output logic                       busy,
    output logic                       abort
);

    localparam int IW = $clog2(N_PORTS);

    if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ingress_fifo_arbiter: N_PORTS must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [IW-1:0]      r_rr_ptr;
    logic [N_PORTS-1:0] w_win;
    logic [IW-1:0]      w_win_idx;
    logic               w_any;
    logic               w_frame_done;
    logic               w_timeout;
    logic [IW-1:0]      w_ptr_after;

    rr_pick #(.N(N_PORTS)) u_rr_pick (
        .req    (req),
        .ptr    (r_rr_ptr),
        .winner (w_win),
        .idx    (w_win_idx),
        .any    (w_any)
    );

    // Only the owner's eof/req matter; a dropped req is an abandoned frame.
    assign w_frame_done = eof[grant_id] || !req[grant_id];
    assign w_ptr_after  = (grant_id == IW'(N_PORTS - 1)) ? '0 : grant_id + 1'b1;

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state != GRANT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Fires on the edge where the count reaches TIMEOUT_CYC.
    assign w_timeout = (r_state == GRANT) && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any && !H_fifo_afull && !P_fifo_afull) w_state_nxt = GRANT;
            GRANT:   if (w_frame_done || w_timeout) w_state_nxt = RELEASE;
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The pointer advances on the edge into RELEASE so it is settled before IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            abort    <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            abort <= 1'b0;
            if (r_state == IDLE && w_state_nxt == GRANT) begin
                grant    <= w_win;
                grant_id <= w_win_idx;
                busy     <= 1'b1;
            end else if (r_state == GRANT && w_state_nxt == RELEASE) begin
                grant    <= '0;
                grant_id <= '0;
                busy     <= 1'b0;
                abort    <= w_timeout && !w_frame_done;
                r_rr_ptr <= w_ptr_after;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ingress_fifo_arbiter.sv
// ============================================================================
// tb_ingress_fifo_arbiter : directed self-checking bench for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ingress_fifo_arbiter;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] eof;
    logic          hf;
    logic          pf;
    logic [NP-1:0] grant;
    logic [1:0]    grant_id;
    logic          busy;
    logic          abort;

    int errors = 0;
    int checks = 0;

    ingress_fifo_arbiter #(.N_PORTS(NP), .TIMEOUT_CYC(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .eof          (eof),
        .H_fifo_afull (hf),
        .P_fifo_afull (pf),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy         (busy),
        .abort        (abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int e;
        rst = 1'b1; req = '0; eof = '0; hf = 1'b0; pf = 1'b0;
        step(); step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_id", int'(grant_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_abort", int'(abort), 0);
        rst = 1'b0;

        // Fairness from rr_ptr=0: expected order 0,1,2,3,0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            step();
            chk("rr_grant", int'(grant), 1 << e);
            chk("rr_id", int'(grant_id), e);
            step(); step(); step(); step();
            chk("rr_hold", int'(grant), 1 << e);
            eof = 4'(1 << e);
            if (k == 4) req = '0;
            step();
            chk("rr_release", int'(grant), 0);
            eof = '0;
            step();
        end

        // Single request; eof and req drop together; rr_ptr must become 3.
        req = 4'b0100;
        step();
        chk("single_grant", int'(grant), 4);
        chk("single_id", int'(grant_id), 2);
        chk("single_busy", int'(busy), 1);
        step(); step();
        eof = 4'b0100; req = '0;
        step();
        chk("single_rel_grant", int'(grant), 0);
        chk("single_rel_busy", int'(busy), 0);
        eof = '0; req = 4'b1111;
        step();
        chk("no_grant_in_release", int'(grant), 0);
        step();
        chk("ptr3_grant", int'(grant), 8);
        chk("ptr3_id", int'(grant_id), 3);
        eof = 4'b1000; req = '0;
        step();
        eof = '0;
        step();

        // Backpressure: afull blocks new grants but never revokes one.
        pf = 1'b1; req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("bp_blocked", int'(busy), 0);
        end
        pf = 1'b0;
        step();
        chk("bp_grant", int'(grant), 1);
        pf = 1'b1; hf = 1'b1;
        step(); step(); step();
        chk("bp_kept", int'(grant), 1);
        req = '0;
        step();
        chk("bp_abandon_grant", int'(grant), 0);
        chk("bp_abandon_abort", int'(abort), 0);
        pf = 1'b0; hf = 1'b0;
        step();

        // Stray events from non-owners are ignored; rr_ptr is 1 here.
        req = 4'b0010;
        step();
        chk("stray_grant", int'(grant), 2);
        eof = 4'b1000; req = 4'b0110;
        step();
        chk("stray_eof3", int'(grant), 2);
        eof = '0; req = 4'b0010;
        step();
        chk("stray_req2_low", int'(grant), 2);
        req = 4'b0110;
        step();
        chk("stray_req2_high", int'(grant), 2);
        req = 4'b0100;
        step();
        chk("drop_req_grant", int'(grant), 0);
        chk("drop_req_abort", int'(abort), 0);
        step(); step();
        chk("next_port2", int'(grant), 4);

        // Reset mid-grant; rr_ptr back to 0 so 0b1001 picks port 0, not 3.
        rst = 1'b1;
        step();
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_id", int'(grant_id), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_abort", int'(abort), 0);
        rst = 1'b0; req = 4'b1001;
        step();
        chk("post_rst_grant", int'(grant), 1);
        eof = 4'b0001; req = '0;
        step();
        eof = '0;
        step();
        req = 4'b1000;
        step();
        chk("post_rst_port3", int'(grant), 8);
        eof = 4'b1000; req = '0;
        step();
        eof = '0;
        step();

        // Watchdog: owner never sends eof.
        req = 4'b0100;
        step();
        chk("wd_grant", int'(grant), 4);
`ifdef ARB_WATCHDOG_EN
        for (int k = 0; k < 63; k++) step();
        chk("wd_pre_abort", int'(abort), 0);
        chk("wd_pre_grant", int'(grant), 4);
        step();
        chk("wd_abort", int'(abort), 1);
        chk("wd_grant_dropped", int'(grant), 0);
        step();
        chk("wd_abort_pulse", int'(abort), 0);
`else
        for (int k = 0; k < 1000; k++) begin
            step();
            if (abort !== 1'b0) chk("nowd_abort", int'(abort), 0);
        end
        chk("nowd_held", int'(grant), 4);
        chk("nowd_busy", int'(busy), 1);
`endif
        req = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
